// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter
//   Two-port round-robin arbiter and sequencer for the shared mul/div unit.
//   Accepts one request at a time from requester 0 or 1, issues it to the
//   unit, captures the unit result and returns it to the requester that
//   issued it. Only one operation is ever in flight.
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   reqN_valid/ready             request handshake (N = 0, 1)
//   reqN_src0/src1/op/sign       request payload (op: 01 MUL, 10 DIV, else illegal)
//   respN_valid/ready            result handshake back to requester N
//   respN_res0/res1              result (MUL lo/hi, DIV quotient/remainder)
//   md_in_valid/ready            issue handshake to the unit
//   md_src0/src1/op/sign         latched operation fields to the unit
//   md_out_valid/ready           result handshake from the unit
//   md_res0/res1                 unit result
//   busy                         arbiter not idle
//   owner                        requester currently served
module muldiv_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_src0,
  input  logic [W-1:0] req0_src1,
  input  logic [1:0]   req0_op,
  input  logic         req0_sign,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_src0,
  input  logic [W-1:0] req1_src1,
  input  logic [1:0]   req1_op,
  input  logic         req1_sign,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [W-1:0] resp0_res0,
  output logic [W-1:0] resp0_res1,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [W-1:0] resp1_res0,
  output logic [W-1:0] resp1_res1,
  output logic         md_in_valid,
  input  logic         md_in_ready,
  output logic [W-1:0] md_src0,
  output logic [W-1:0] md_src1,
  output logic [1:0]   md_op,
  output logic         md_sign,
  input  logic         md_out_valid,
  output logic         md_out_ready,
  input  logic [W-1:0] md_res0,
  input  logic [W-1:0] md_res1,
  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state, state_nx;
  logic         prio;
  logic [W-1:0] src0_q, src1_q, res0_q, res1_q;
  logic [1:0]   op_q;
  logic         sign_q;

  logic         gnt;
  logic         accept;
  logic         legal;
  logic         resp_done;
  logic         res_capture;
  logic [W-1:0] sel_src0, sel_src1;
  logic [1:0]   sel_op;
  logic         sel_sign;

  always_comb begin
    state_nx     = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;
    md_in_valid  = 1'b0;
    md_out_ready = 1'b0;
    accept       = 1'b0;
    resp_done    = 1'b0;
    res_capture  = 1'b0;

    // Ties go to prio; otherwise the lone valid requester (req1 iff only it is valid).
    gnt      = (req0_valid && req1_valid) ? prio : req1_valid;
    sel_src0 = gnt ? req1_src0 : req0_src0;
    sel_src1 = gnt ? req1_src1 : req0_src1;
    sel_op   = gnt ? req1_op   : req0_op;
    sel_sign = gnt ? req1_sign : req0_sign;
    legal    = (sel_op == 2'b01) || (sel_op == 2'b10);

    unique case (state)
      IDLE: begin
        accept     = req0_valid || req1_valid;
        req0_ready = accept && !gnt;
        req1_ready = accept && gnt;
        if (accept) state_nx = legal ? ISSUE : RESP;
      end
      ISSUE: begin
        md_in_valid = 1'b1;
        if (md_in_ready) state_nx = WAIT;
      end
      WAIT: begin
        md_out_ready = 1'b1;
        res_capture  = md_out_valid;
        if (md_out_valid) state_nx = RESP;
      end
      RESP: begin
        resp0_valid = !owner;
        resp1_valid = owner;
        resp_done   = owner ? resp1_ready : resp0_ready;
        if (resp_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio   <= 1'b0;
      owner  <= 1'b0;
      src0_q <= '0;
      src1_q <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      res0_q <= '0;
      res1_q <= '0;
    end else begin
      if (accept) begin
        owner  <= gnt;
        src0_q <= sel_src0;
        src1_q <= sel_src1;
        op_q   <= sel_op;
        sign_q <= sel_sign;
        // Illegal ops skip the unit and answer with a zero result.
        if (!legal) begin
          res0_q <= '0;
          res1_q <= '0;
        end
      end
      if (res_capture) begin
        res0_q <= md_res0;
        res1_q <= md_res1;
      end
      if (resp_done) prio <= !owner;
    end
  end

  assign md_src0    = src0_q;
  assign md_src1    = src1_q;
  assign md_op      = op_q;
  assign md_sign    = sign_q;
  assign resp0_res0 = res0_q;
  assign resp0_res1 = res1_q;
  assign resp1_res0 = res0_q;
  assign resp1_res1 = res1_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter
//   Self-checking bench for muldiv_arbiter. The bench plays the role of both
//   requesters and of the mul/div unit; unit results are hand-computed
//   constants held in the vector table.
module tb_muldiv_arbiter;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_sign;
  logic [W-1:0] req0_src0, req0_src1;
  logic [1:0]   req0_op;
  logic         req1_valid, req1_ready, req1_sign;
  logic [W-1:0] req1_src0, req1_src1;
  logic [1:0]   req1_op;
  logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [W-1:0] resp0_res0, resp0_res1, resp1_res0, resp1_res1;
  logic         md_in_valid, md_in_ready, md_sign;
  logic [W-1:0] md_src0, md_src1;
  logic [1:0]   md_op;
  logic         md_out_valid, md_out_ready;
  logic [W-1:0] md_res0, md_res1;
  logic         busy, owner;

  muldiv_arbiter #(.W(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src0(req0_src0),
    .req0_src1(req0_src1), .req0_op(req0_op), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src0(req1_src0),
    .req1_src1(req1_src1), .req1_op(req1_op), .req1_sign(req1_sign),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_res0(resp0_res0), .resp0_res1(resp0_res1),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_res0(resp1_res0), .resp1_res1(resp1_res1),
    .md_in_valid(md_in_valid), .md_in_ready(md_in_ready),
    .md_src0(md_src0), .md_src1(md_src1), .md_op(md_op), .md_sign(md_sign),
    .md_out_valid(md_out_valid), .md_out_ready(md_out_ready),
    .md_res0(md_res0), .md_res1(md_res1),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        port;
    logic [31:0] src0, src1;
    logic [1:0]  op;
    logic        sign;
    logic [31:0] ures0, ures1;   // what the unit returns
    logic [31:0] exp0, exp1;     // what the requester must see
    int unsigned stall;          // cycles md_in_ready held low in ISSUE
    int unsigned dwait;          // cycles in WAIT before md_out_valid
    int unsigned hold;           // cycles resp_ready held low in RESP
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic port, input logic valid, input vec_t v);
    if (port) begin
      req1_valid = valid; req1_src0 = v.src0; req1_src1 = v.src1;
      req1_op = v.op; req1_sign = v.sign;
    end else begin
      req0_valid = valid; req0_src0 = v.src0; req0_src1 = v.src1;
      req0_op = v.op; req0_sign = v.sign;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Starts one cycle after the accept edge and runs to the return to IDLE.
  task automatic finish_txn(input vec_t v);
    logic legal;
    legal = (v.op == 2'b01) || (v.op == 2'b10);
    chk("owner", {31'b0, owner}, {31'b0, v.port});
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("req0_ready_busy", {31'b0, req0_ready}, 32'd0);
    chk("req1_ready_busy", {31'b0, req1_ready}, 32'd0);
    if (legal) begin
      for (int unsigned i = 0; i < v.stall; i++) begin
        md_in_ready  = 1'b0;
        md_out_valid = 1'b1;          // must be ignored outside WAIT
        md_res0 = 32'hDEADBEEF; md_res1 = 32'hDEADBEEF;
        #1;
        chk("stall_in_valid", {31'b0, md_in_valid}, 32'd1);
        chk("stall_out_ready", {31'b0, md_out_ready}, 32'd0);
        chk("stall_src0", md_src0, v.src0);
        chk("stall_op", {30'b0, md_op}, {30'b0, v.op});
        step();
      end
      md_out_valid = 1'b0;
      md_in_ready  = 1'b1;
      #1;
      chk("issue_in_valid", {31'b0, md_in_valid}, 32'd1);
      chk("issue_src0", md_src0, v.src0);
      chk("issue_src1", md_src1, v.src1);
      chk("issue_op", {30'b0, md_op}, {30'b0, v.op});
      chk("issue_sign", {31'b0, md_sign}, {31'b0, v.sign});
      step();
      md_in_ready = 1'b0;
      for (int unsigned i = 0; i < v.dwait; i++) begin
        chk("wait_out_ready", {31'b0, md_out_ready}, 32'd1);
        chk("wait_in_valid", {31'b0, md_in_valid}, 32'd0);
        chk("wait_resp_valid", {30'b0, resp1_valid, resp0_valid}, 32'd0);
        step();
      end
      md_out_valid = 1'b1;
      md_res0 = v.ures0; md_res1 = v.ures1;
      #1;
      chk("wait_out_ready", {31'b0, md_out_ready}, 32'd1);
      step();
      md_out_valid = 1'b0;
      md_res0 = '0; md_res1 = '0;
    end else begin
      chk("illegal_no_issue", {31'b0, md_in_valid}, 32'd0);
    end
    for (int unsigned i = 0; i <= v.hold; i++) begin
      if (i == v.hold) begin
        if (v.port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      end
      #1;
      chk("resp_valid_own", {31'b0, v.port ? resp1_valid : resp0_valid}, 32'd1);
      chk("resp_valid_other", {31'b0, v.port ? resp0_valid : resp1_valid}, 32'd0);
      chk("resp_res0", v.port ? resp1_res0 : resp0_res0, v.exp0);
      chk("resp_res1", v.port ? resp1_res1 : resp0_res1, v.exp1);
      chk("resp_req_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      chk("resp_out_ready", {31'b0, md_out_ready}, 32'd0);
      step();
    end
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    chk("idle_after_resp", {31'b0, busy}, 32'd0);
  endtask

  // Lone requester: accept in IDLE, then run to completion.
  task automatic run_vec(input vec_t v);
    set_req(v.port, 1'b1, v);
    #1;
    chk("grant_own", {31'b0, v.port ? req1_ready : req0_ready}, 32'd1);
    chk("grant_other", {31'b0, v.port ? req0_ready : req1_ready}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    step();
    set_req(v.port, 1'b0, v);
    finish_txn(v);
  endtask

  vec_t tbl[7];
  vec_t t0, t1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t limit 200000", $time);
    $fatal(1);
  end

  initial begin
    // signed MUL -3*5 = -15 -> hi FFFFFFFF, lo FFFFFFF1
    tbl[0] = '{1'b0, 32'hFFFFFFFD, 32'd5, 2'b01, 1'b1, 32'hFFFFFFF1, 32'hFFFFFFFF,
               32'hFFFFFFF1, 32'hFFFFFFFF, 0, 0, 0};
    // unsigned DIV 100/7 = 14 r 2, slow unit
    tbl[1] = '{1'b1, 32'd100, 32'd7, 2'b10, 1'b0, 32'd14, 32'd2, 32'd14, 32'd2, 0, 6, 0};
    // illegal op 11: zero result, unit untouched
    tbl[2] = '{1'b0, 32'h12345678, 32'h9, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0};
    // unsigned DIV 50/5 = 10 r 0, to put a non-zero result in the register
    tbl[3] = '{1'b1, 32'd50, 32'd5, 2'b10, 1'b0, 32'd10, 32'd0, 32'd10, 32'd0, 0, 2, 0};
    // illegal op 00 from req1 clears the previous result
    tbl[4] = '{1'b1, 32'hAAAA5555, 32'h1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0};
    // unsigned MUL 0x10000*0x10000 = 2^32 -> lo 0, hi 1, unit stalls 5 cycles
    tbl[5] = '{1'b0, 32'h00010000, 32'h00010000, 2'b01, 1'b0, 32'h0, 32'h1,
               32'h0, 32'h1, 5, 0, 0};
    // signed DIV -100/7 = -14 r -2, back-to-back from req0, held response
    tbl[6] = '{1'b0, 32'hFFFFFF9C, 32'd7, 2'b10, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE,
               32'hFFFFFFF2, 32'hFFFFFFFE, 0, 3, 3};

    reset = 1'b1;
    req0_valid = 0; req0_src0 = '0; req0_src1 = '0; req0_op = '0; req0_sign = 0;
    req1_valid = 0; req1_src0 = '0; req1_src1 = '0; req1_op = '0; req1_sign = 0;
    resp0_ready = 0; resp1_ready = 0;
    md_in_ready = 0; md_out_valid = 0; md_res0 = '0; md_res1 = '0;
    step();
    step();

    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_owner", {31'b0, owner}, 32'd0);
    chk("rst_valids", {29'b0, md_in_valid, resp1_valid, resp0_valid}, 32'd0);
    chk("rst_readies", {29'b0, md_out_ready, req1_ready, req0_ready}, 32'd0);
    chk("rst_md_src0", md_src0, 32'd0);
    chk("rst_md_src1", md_src1, 32'd0);
    chk("rst_md_op", {29'b0, md_sign, md_op}, 32'd0);
    chk("rst_res", resp0_res0 | resp0_res1, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Tie after reset: req0 wins, req1 stalls through a 10-cycle held response.
    do_reset();
    t0 = '{1'b0, 32'd6, 32'd7, 2'b01, 1'b0, 32'd42, 32'd0, 32'd42, 32'd0, 0, 0, 10};
    t1 = '{1'b1, 32'd81, 32'd9, 2'b10, 1'b0, 32'd9, 32'd0, 32'd9, 32'd0, 0, 1, 0};
    set_req(1'b0, 1'b1, t0);
    set_req(1'b1, 1'b1, t1);
    #1;
    chk("tie1_req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("tie1_req1_ready", {31'b0, req1_ready}, 32'd0);
    step();
    set_req(1'b0, 1'b0, t0);
    finish_txn(t0);
    chk("tie1_req1_next", {31'b0, req1_ready}, 32'd1);
    step();
    set_req(1'b1, 1'b0, t1);
    finish_txn(t1);

    // Second tie after req1 was served: req0 wins again.
    set_req(1'b0, 1'b1, t0);
    set_req(1'b1, 1'b1, t1);
    #1;
    chk("tie2_req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("tie2_req1_ready", {31'b0, req1_ready}, 32'd0);
    step();
    set_req(1'b0, 1'b0, t0);
    finish_txn(t0);
    step();
    set_req(1'b1, 1'b0, t1);
    finish_txn(t1);

    // Reset while waiting on the unit.
    set_req(1'b0, 1'b1, tbl[0]);
    step();
    set_req(1'b0, 1'b0, tbl[0]);
    md_in_ready = 1'b1;
    step();
    md_in_ready = 1'b0;
    #1;
    chk("pre_rst_wait", {31'b0, md_out_ready}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wrst_busy", {31'b0, busy}, 32'd0);
    chk("wrst_valids", {29'b0, md_in_valid, resp1_valid, resp0_valid}, 32'd0);
    chk("wrst_out_ready", {31'b0, md_out_ready}, 32'd0);
    chk("wrst_owner", {31'b0, owner}, 32'd0);
    // A late unit result in IDLE is ignored.
    md_out_valid = 1'b1;
    md_res0 = 32'hDEADBEEF; md_res1 = 32'hDEADBEEF;
    step();
    md_out_valid = 1'b0;
    chk("stray_result_busy", {31'b0, busy}, 32'd0);
    chk("stray_result_res", resp0_res0, 32'd0);
    run_vec(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
